// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between
// NREQ valid/ready/last requesters. A grant is held for a whole packet so
// packets stay contiguous in the FIFO. A beat-count watchdog releases runaway
// packets and pulses len_err.
module fifo_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DW     = 8,
  parameter int MAXLEN = 16,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  input  logic               wfull,
  output logic               winc,
  output logic [DW-1:0]      wdata,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               len_err
);

  localparam int BCW = $clog2(MAXLEN + 1);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(MAXLEN - 1);
  localparam logic [IDW-1:0] ID_MAX    = IDW'(NREQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [IDW-1:0]   grant_id_r, grant_nxt_s;
  logic [IDW-1:0]   rr_ptr_r, rr_nxt_s;
  logic [BCW-1:0]   beat_cnt_r, beat_nxt_s;
  logic             len_err_r, len_err_nxt_s;

  logic             pick_valid_s;
  logic [IDW-1:0]   pick_id_s;
  logic [IDW-1:0]   cand_s;
  logic [IDW-1:0]   next_id_s;
  logic             winc_s;
  logic [NREQ-1:0]  ready_s;

  // Round-robin pick: scan from rr_ptr upward; the reverse loop lets the
  // candidate closest to rr_ptr overwrite the others.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_id_s    = '0;
    cand_s       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s = IDW'((int'(rr_ptr_r) + k) % NREQ);
      if (req_valid[cand_s]) begin
        pick_valid_s = 1'b1;
        pick_id_s    = cand_s;
      end else begin
        pick_valid_s = pick_valid_s;
        pick_id_s    = pick_id_s;
      end
    end
  end

  // Successor of the current grant, wrapping modulo NREQ (any NREQ).
  always_comb begin
    if (grant_id_r == ID_MAX) begin
      next_id_s = '0;
    end else begin
      next_id_s = grant_id_r + IDW'(1);
    end
  end

  // Output decode from registered state; wfull gates the transfer directly.
  always_comb begin
    ready_s = '0;
    if ((state_r == ST_GRANT) && !wfull) begin
      ready_s[grant_id_r] = 1'b1;
    end else begin
      ready_s = '0;
    end
    winc_s = (state_r == ST_GRANT) & req_valid[grant_id_r] & ~wfull;
  end

  // Next-state logic: arbitration in IDLE, packet tracking and watchdog in GRANT.
  always_comb begin
    state_nxt_s   = state_r;
    grant_nxt_s   = grant_id_r;
    rr_nxt_s      = rr_ptr_r;
    beat_nxt_s    = beat_cnt_r;
    len_err_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        beat_nxt_s = '0;
        if (pick_valid_s) begin
          state_nxt_s = ST_GRANT;
          grant_nxt_s = pick_id_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (winc_s) begin
          if (req_last[grant_id_r]) begin
            state_nxt_s = ST_IDLE;
            rr_nxt_s    = next_id_s;
            beat_nxt_s  = '0;
          end else if (beat_cnt_r == BEAT_LAST) begin
            // Runaway packet: release; remaining beats become a new packet.
            state_nxt_s   = ST_IDLE;
            rr_nxt_s      = next_id_s;
            beat_nxt_s    = '0;
            len_err_nxt_s = 1'b1;
          end else begin
            beat_nxt_s = beat_cnt_r + BCW'(1);
          end
        end else begin
          // Stalled by wfull or by the granted requester dropping valid.
          beat_nxt_s = beat_cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        beat_nxt_s  = '0;
      end
    endcase
  end

  // State and bookkeeping registers with asynchronous active-low reset.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r    <= ST_IDLE;
      grant_id_r <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
      len_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      grant_id_r <= grant_nxt_s;
      rr_ptr_r   <= rr_nxt_s;
      beat_cnt_r <= beat_nxt_s;
      len_err_r  <= len_err_nxt_s;
    end
  end

  assign req_ready = ready_s;
  assign winc      = winc_s;
  assign wdata     = req_data[int'(grant_id_r) * DW +: DW];
  assign grant_id  = grant_id_r;
  assign busy      = (state_r == ST_GRANT);
  assign len_err   = len_err_r;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO write domain. Shares one FIFO write port (winc/wdata, back-pressured by wfull) between NREQ requesters, each using a valid/ready/last handshake. A grant is held for a whole packet so packets stay contiguous in the FIFO. A length watchdog forcibly releases runaway packets. Runs entirely in the write clock domain, directly in front of the FIFO write-pointer/full logic.

## Interface
- NREQ, 4: number of requesters (2..8)
- DW, 8: data width
- MAXLEN, 16: maximum beats per packet before forced release (>=1)
- IDW, $clog2(NREQ): grant index width (derived)

- wclk  in  1  write-domain clock
- wrst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  per-requester beat valid
- req_data  in  NREQ*DW  per-requester data; requester i occupies bits [i*DW +: DW]
- req_last  in  NREQ  per-requester last beat of packet
- req_ready  out  NREQ  per-requester beat accepted this cycle
- wfull  in  1  FIFO full flag (registered, from write-pointer logic)
- winc  out  1  FIFO write enable
- wdata  out  DW  FIFO write data
- grant_id  out  IDW  currently granted requester
- busy  out  1  high while a packet is granted
- len_err  out  1  one-cycle pulse on watchdog release

## Operation
- States: IDLE, GRANT. Registers: state, grant_id, rr_ptr (IDW), beat_cnt ($clog2(MAXLEN+1) bits), len_err.
- IDLE: if any req_valid is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NREQ. Register it into grant_id and go to GRANT. No beat is transferred in IDLE. Set beat_cnt to 0.
- GRANT: outputs are combinational from registered state:
  - winc = req_valid[grant_id] & ~wfull
  - req_ready[i] = (i==grant_id) & ~wfull; all other bits are 0
  - wdata = req_data[grant_id] in every state (don't-care when winc=0)
- A beat transfers when winc=1; beat_cnt then increments.
- Release: on a transfer with req_last[grant_id]=1, go to IDLE and set rr_ptr to (grant_id+1) mod NREQ.
- Watchdog: on a transfer with req_last=0 where beat_cnt==MAXLEN-1, also release (same rr_ptr update) and pulse len_err for one cycle. The requester's remaining beats form a new packet at its next grant.
- A requester dropping req_valid mid-packet does not release the grant. The arbiter waits with no timeout.
- wfull=1 stalls the transfer: winc=0, ready=0, and state, grant_id and beat_cnt are held.
- busy = (state==GRANT).
- Requests from non-granted requesters are ignored until the next IDLE cycle.

## Timing
- Reset (async assert, sync release): state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0, len_err=0. Hence winc=0, req_ready=0, busy=0.
- Arbitration latency: a request in IDLE at cycle N gives busy=1 and first possible winc at cycle N+1.
- Throughput: one beat per cycle while granted and not full.
- After the last beat, the next packet's first beat is at the earliest 2 cycles later (1 IDLE bubble).
- A single-beat packet (req_last with the first beat) occupies exactly 1 GRANT cycle.
- wfull is sampled combinationally in the same cycle. The FIFO's full flag already accounts for a write in the previous cycle, so no overflow occurs.
- Reset asserted mid-packet: immediately returns to IDLE, and the packet is truncated with no len_err.
- The rr_ptr wrap uses modulo NREQ for any NREQ, including non-powers of 2.

## Test plan
- Single requester, 3-beat packet (data 0xA1, 0xA2, 0xA3, last on the third) -> busy rises 1 cycle after valid; winc high for 3 consecutive cycles with wdata A1/A2/A3; IDLE on the 4th cycle; rr_ptr=1.
- All 4 requesters continuously valid, each packet 2 beats -> grant order 0,1,2,3,0. Each packet is 2 GRANT cycles followed by 1 IDLE cycle, giving 8 beats in 12 cycles.
- wfull forced high for 3 cycles mid-packet of requester 2 -> winc=0 and req_ready=0 during the stall; grant_id stays 2; the beat held at the stall is written in the first cycle after wfull falls.
- MAXLEN=16, requester 1 streams 20 beats with no last -> forced release after beat 16 with a one-cycle len_err pulse. Other requesters are then served in round-robin order. Requester 1's remaining 4 beats follow at its next grant.
- Requester 3 drops valid for 5 cycles mid-packet while requester 0 is valid -> grant stays 3, winc=0, requester 0 is not served; the packet resumes when requester 3 reasserts valid.
- Reset asserted mid-packet with grant_id=2 and beat_cnt=5 -> all outputs return to reset values asynchronously. After release, the arbiter serves requester 0 first when all requesters are valid.
